scan_sel_gen: RTL



---
 rtl/scan_pkg.sv | 16 +
 rtl/clk_div_tick.sv | 28 ++
 rtl/scan_sel_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared encodings for the scan select generator and its decoder-side consumers.
package scan_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam logic [2:0] SEL_MAX = 3'd7;

endpackage

// File: rtl/clk_div_tick.sv
// Prescaler: one-cycle tick_o every CNT_MAX+1 enabled clocks; disabling restarts the period.
module clk_div_tick #(
  parameter int CNT_MAX = 49_999
) (
  input  logic Clk,
  input  logic Rst,
  input  logic en,
  output logic tick_o
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TC = CW'(CNT_MAX);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_cnt <= '0;
    end else if (!en || div_cnt == TC) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick_o = en && (div_cnt == TC);

endmodule

// File: rtl/scan_sel_gen.sv
// Timed 3-bit select generator for a 3-8 decoder: up, down, ping-pong, hold and single-step.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int CNT_MAX = 49_999
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       step,
  output logic [2:0] sel,
  output logic       tick,
  output logic       frame_done
);

  logic       div_tick;
  logic       adv;
  logic [2:0] sel_nxt;
  logic       fd_nxt;
  logic [1:0] last_mode;
  dir_t       pp_dir;
  dir_t       pp_dir_nxt;
  dir_t       dir_cur;

  clk_div_tick #(
    .CNT_MAX(CNT_MAX)
  ) u_div (
    .Clk   (Clk),
    .Rst   (Rst),
    .en    (en),
    .tick_o(div_tick)
  );

  assign adv = div_tick | (~en & step);

  always_comb begin
    sel_nxt    = sel;
    fd_nxt     = 1'b0;
    pp_dir_nxt = pp_dir;
    dir_cur    = pp_dir;
    // Freshly entered ping-pong: only an index parked at the top can head down.
    if (mode != last_mode) begin
      dir_cur = (sel == SEL_MAX) ? DIR_DN : DIR_UP;
    end
    unique case (mode)
      MODE_UP: begin
        sel_nxt = sel + 3'd1;
        fd_nxt  = (sel == SEL_MAX);
      end
      MODE_DN: begin
        sel_nxt = sel - 3'd1;
        fd_nxt  = (sel == 3'd0);
      end
      MODE_PP: begin
        if (dir_cur == DIR_UP) begin
          sel_nxt    = sel + 3'd1;
          pp_dir_nxt = (sel_nxt == SEL_MAX) ? DIR_DN : DIR_UP;
        end else begin
          sel_nxt    = sel - 3'd1;
          fd_nxt     = (sel_nxt == 3'd0);
          pp_dir_nxt = fd_nxt ? DIR_UP : DIR_DN;
        end
      end
      default: begin
      end
    endcase
  end

  // last_mode resets to ping-pong so a reset in that mode resumes from pp_dir=UP.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sel        <= 3'd0;
      tick       <= 1'b0;
      frame_done <= 1'b0;
      pp_dir     <= DIR_UP;
      last_mode  <= MODE_PP;
    end else begin
      tick       <= adv;
      frame_done <= adv & fd_nxt;
      if (adv) begin
        sel       <= sel_nxt;
        pp_dir    <= pp_dir_nxt;
        last_mode <= mode;
      end
    end
  end

endmodule
